// File: rtl/display_pkg.sv
// Shared display-driver definitions: digit width, converter state encoding,
// and the leading-zero blanking rule used by every block that drives the 7-seg digits.
package display_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MAX_DIGITS = 10;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} b2b_state_t;

    // Digits above the requested count are ignored, so callers zero-extend and truncate.
    function automatic logic [MAX_DIGITS-1:0] blank_mask(
        input logic [DIGIT_W*MAX_DIGITS-1:0] bcd,
        input int                            digits
    );
        logic [MAX_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '1;
        all_zero = 1'b1;
        for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
            if (i < digits) begin
                all_zero = all_zero & (bcd[DIGIT_W*i +: DIGIT_W] == '0);
            end
            mask[i] = all_zero;
        end
        mask[0] = 1'b0;
        return mask;
    endfunction

    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with leading-zero blanking mask,
// one bit per cycle, valid/ready on both sides, one conversion in flight.
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_W-1:0]           in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic [DIGITS-1:0]         out_blank
);

    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(IN_W);
    localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

    if (IN_W < 1 || IN_W > 32) begin : g_bad_in_w
        $error("bin_to_bcd_seq: IN_W must be within 1..32");
    end
    if (DIGITS < 1 || DIGITS > MAX_DIGITS ||
        pow10(DIGITS) <= ((64'd1 << IN_W) - 64'd1)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS cannot hold the largest IN_W value");
    end

    b2b_state_t                state;
    logic [IN_W-1:0]           bin_sr;
    logic [BCD_W-1:0]          bcd_sr;
    logic [CNT_W-1:0]          cnt;
    logic [BCD_W-1:0]          corrected;
    logic [BCD_W-1:0]          bcd_next;
    logic [DIGIT_W*MAX_DIGITS-1:0] bcd_ext;
    logic [DIGITS-1:0]         blank_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (bcd_sr[DIGIT_W*g +: DIGIT_W]),
            .q (corrected[DIGIT_W*g +: DIGIT_W])
        );
    end

    assign bcd_next = {corrected[BCD_W-2:0], bin_sr[IN_W-1]};
    assign in_ready = (state == IDLE);

    always_comb begin
        bcd_ext                 = '0;
        bcd_ext[BCD_W-1:0]      = bcd_next;
        blank_next              = DIGITS'(blank_mask(bcd_ext, DIGITS));
    end

    // The last SHIFT step writes its result straight into the output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bin_sr    <= '0;
            bcd_sr    <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            out_blank <= BLANK_RST;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= in_bin;
                        bcd_sr <= '0;
                        cnt    <= CNT_INIT;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_sr <= bin_sr << 1;
                    bcd_sr <= bcd_next;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        out_bcd   <= bcd_next;
                        out_blank <= blank_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
